// File: rtl/car_types_pkg.sv
// Shared types for the intersection car counters: traffic light encoding and
// the round-robin pointer wrap helper.
package car_types_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } strafic_light_t;

    function automatic int next_rr_idx(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a raw level input; the pulse is high in the first
// cycle the level is seen high after being low.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig;
        end
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/multi_lane_car_counter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping, and flags whether any grant was made.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_lane_car_counter.sv
// Queue-depth tracker for NUM_LANES lanes sharing one junction; a round-robin
// arbiter lets at most one car cross per cycle.
module multi_lane_car_counter
    import car_types_pkg::*;
#(
    parameter  int NUM_LANES = 4,
    parameter  int MAX_CARS  = 9,
    localparam int CNT_W     = $clog2(MAX_CARS + 1),
    localparam int TOT_W     = $clog2(NUM_LANES * MAX_CARS + 1),
    localparam int PTR_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic           [NUM_LANES-1:0]      car_arrived_in,
    input  logic           [NUM_LANES-1:0]      cross_req_in,
    input  strafic_light_t [NUM_LANES-1:0]      lane_light,
    output logic [NUM_LANES-1:0][CNT_W-1:0]     car_counter,
    output logic           [NUM_LANES-1:0]      cross_grant,
    output logic           [NUM_LANES-1:0]      lane_full,
    output logic           [NUM_LANES-1:0]      arrival_drop,
    output logic           [NUM_LANES-1:0]      req_drop,
    output logic           [TOT_W-1:0]          total_cars
);

    logic [NUM_LANES-1:0] arr_rise;
    logic [NUM_LANES-1:0] req_rise;
    logic [NUM_LANES-1:0] is_green;
    logic [NUM_LANES-1:0] req_set;
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] eligible;
    logic                 grant_valid;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     gnt_idx;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        edge_detect u_arr_edge (
            .clk  (clk),
            .rst  (rst),
            .sig  (car_arrived_in[i]),
            .rise (arr_rise[i])
        );

        edge_detect u_req_edge (
            .clk  (clk),
            .rst  (rst),
            .sig  (cross_req_in[i]),
            .rise (req_rise[i])
        );

        // An accepted request competes for the junction in its own rise cycle.
        assign is_green[i]     = (lane_light[i] == GREEN);
        assign req_set[i]      = req_rise[i] & is_green[i] & (car_counter[i] != '0) & ~pending[i];
        assign eligible[i]     = (pending[i] | req_set[i]) & is_green[i];
        assign req_drop[i]     = pending[i] & ~is_green[i];
        assign lane_full[i]    = (car_counter[i] == CNT_W'(MAX_CARS));
        assign arrival_drop[i] = arr_rise[i] & ~cross_grant[i] & lane_full[i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pending[i] <= 1'b0;
            end else if (cross_grant[i] || req_drop[i]) begin
                pending[i] <= 1'b0;
            end else if (req_set[i]) begin
                pending[i] <= 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                car_counter[i] <= '0;
            end else if (arr_rise[i] && !cross_grant[i] && !lane_full[i]) begin
                car_counter[i] <= car_counter[i] + CNT_W'(1);
            end else if (!arr_rise[i] && cross_grant[i]) begin
                car_counter[i] <= car_counter[i] - CNT_W'(1);
            end
        end
    end

    rr_arbiter #(
        .N (NUM_LANES)
    ) u_arbiter (
        .req   (eligible),
        .ptr   (rr_ptr),
        .gnt   (cross_grant),
        .valid (grant_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (cross_grant[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= PTR_W'(next_rr_idx(int'(gnt_idx), NUM_LANES));
        end
    end

    always_comb begin
        total_cars = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            total_cars = total_cars + TOT_W'(car_counter[i]);
        end
    end

endmodule

// File: tb/tb_multi_lane_car_counter.sv
// Directed bench for multi_lane_car_counter: inputs change 1 ns after posedge,
// outputs are checked on the following negedge.
module tb_multi_lane_car_counter;
    import car_types_pkg::*;

    logic                       clk;
    logic                       rst;
    logic           [3:0]       car_arrived_in;
    logic           [3:0]       cross_req_in;
    strafic_light_t [3:0]       lane_light;
    strafic_light_t [3:0]       light_cfg;
    logic           [3:0][3:0]  car_counter;
    logic           [3:0]       cross_grant;
    logic           [3:0]       lane_full;
    logic           [3:0]       arrival_drop;
    logic           [3:0]       req_drop;
    logic           [5:0]       total_cars;

    int tests_run    = 0;
    int tests_failed = 0;

    multi_lane_car_counter #(
        .NUM_LANES (4),
        .MAX_CARS  (9)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .car_arrived_in (car_arrived_in),
        .cross_req_in   (cross_req_in),
        .lane_light     (lane_light),
        .car_counter    (car_counter),
        .cross_grant    (cross_grant),
        .lane_full      (lane_full),
        .arrival_drop   (arrival_drop),
        .req_drop       (req_drop),
        .total_cars     (total_cars)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive one cycle of raw levels and lights, then park on the negedge to check.
    task automatic applyStimulus(input logic [3:0] arr, input logic [3:0] req);
        @(posedge clk);
        #1;
        car_arrived_in = arr;
        cross_req_in   = req;
        lane_light     = light_cfg;
        @(negedge clk);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " grant"}, 32'(cross_grant), 32'h0);
        checkOutput({tag, " req_drop"}, 32'(req_drop), 32'h0);
        checkOutput({tag, " arrival_drop"}, 32'(arrival_drop), 32'h0);
    endtask

    initial begin
        rst            = 1'b0;
        car_arrived_in = '0;
        cross_req_in   = '0;
        light_cfg      = {RED, RED, RED, RED};
        lane_light     = light_cfg;

        #12;
        checkOutput("reset total", 32'(total_cars), 32'd0);
        checkOutput("reset full", 32'(lane_full), 32'h0);
        checkIdle("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Lane 0: three arrivals then one request.
        light_cfg[0] = GREEN;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(4'b0001, 4'b0000);
            applyStimulus(4'b0000, 4'b0000);
            checkOutput($sformatf("lane0 count after arrival %0d", k), 32'(car_counter[0]), 32'(k));
        end
        applyStimulus(4'b0000, 4'b0001);
        checkOutput("lane0 grant in rise cycle", 32'(cross_grant), 32'h1);
        checkOutput("lane0 count before edge", 32'(car_counter[0]), 32'd3);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("lane0 grant single pulse", 32'(cross_grant), 32'h0);
        checkOutput("lane0 count after cross", 32'(car_counter[0]), 32'd2);

        // Build counts {3,0,9,1} then reset asynchronously mid-cycle.
        for (int k = 0; k < 9; k++) begin
            applyStimulus((k == 0) ? 4'b1101 : 4'b0100, 4'b0000);
            applyStimulus(4'b0000, 4'b0000);
        end
        checkOutput("pre-reset lane0", 32'(car_counter[0]), 32'd3);
        checkOutput("pre-reset lane2", 32'(car_counter[2]), 32'd9);
        checkOutput("pre-reset lane3", 32'(car_counter[3]), 32'd1);
        checkOutput("pre-reset total", 32'(total_cars), 32'd13);
        checkOutput("pre-reset full", 32'(lane_full), 32'h4);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset counters", 32'(car_counter), 32'h0);
        checkOutput("async reset total", 32'(total_cars), 32'd0);
        checkOutput("async reset full", 32'(lane_full), 32'h0);
        checkIdle("async reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // All lanes green, two cars each, simultaneous requests.
        light_cfg = {GREEN, GREEN, GREEN, GREEN};
        applyStimulus(4'b1111, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b1111, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("all lanes total 8", 32'(total_cars), 32'd8);
        applyStimulus(4'b0000, 4'b1111);
        checkOutput("rr grant lane0", 32'(cross_grant), 32'h1);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("rr grant lane1", 32'(cross_grant), 32'h2);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("rr grant lane2", 32'(cross_grant), 32'h4);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("rr grant lane3", 32'(cross_grant), 32'h8);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("rr grants done", 32'(cross_grant), 32'h0);
        checkOutput("rr counts all 1", 32'(car_counter), 32'h1111);
        checkOutput("rr total 4", 32'(total_cars), 32'd4);

        // Lane 1 to saturation, then a rejected arrival and a netted one.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0010, 4'b0000);
            applyStimulus(4'b0000, 4'b0000);
        end
        checkOutput("lane1 saturated", 32'(car_counter[1]), 32'd9);
        checkOutput("lane1 full flag", 32'(lane_full), 32'h2);
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("lane1 arrival_drop", 32'(arrival_drop), 32'h2);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("lane1 drop single pulse", 32'(arrival_drop), 32'h0);
        checkOutput("lane1 still 9", 32'(car_counter[1]), 32'd9);
        applyStimulus(4'b0010, 4'b0010);
        checkOutput("lane1 netted grant", 32'(cross_grant), 32'h2);
        checkOutput("lane1 netted no drop", 32'(arrival_drop), 32'h0);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("lane1 netted count", 32'(car_counter[1]), 32'd9);
        checkOutput("total after netting", 32'(total_cars), 32'd12);

        // Move the pointer back to lane 0 via a lane 3 crossing.
        applyStimulus(4'b0000, 4'b1000);
        checkOutput("lane3 grant", 32'(cross_grant), 32'h8);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("lane3 emptied", 32'(car_counter[3]), 32'd0);

        // Lane 2 pending behind lane 0, then its light turns red.
        applyStimulus(4'b0000, 4'b0101);
        checkOutput("lane0 wins over lane2", 32'(cross_grant), 32'h1);
        checkOutput("no req_drop yet", 32'(req_drop), 32'h0);
        light_cfg[2] = RED;
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("lane2 req_drop", 32'(req_drop), 32'h4);
        checkOutput("lane2 no grant", 32'(cross_grant), 32'h0);
        checkOutput("lane2 count kept", 32'(car_counter[2]), 32'd1);
        applyStimulus(4'b0000, 4'b0000);
        checkIdle("after light drop");
        checkOutput("lane2 count still 1", 32'(car_counter[2]), 32'd1);
        checkOutput("total after drop", 32'(total_cars), 32'd10);

        // Lane 3 requests that must be ignored: empty lane, then red light.
        applyStimulus(4'b0000, 4'b1000);
        checkIdle("lane3 empty req");
        checkOutput("lane3 empty total", 32'(total_cars), 32'd10);
        applyStimulus(4'b0000, 4'b0000);
        checkIdle("lane3 empty req next");
        checkOutput("lane3 empty total next", 32'(total_cars), 32'd10);
        applyStimulus(4'b1000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("lane3 one car", 32'(car_counter[3]), 32'd1);
        checkOutput("total with lane3 car", 32'(total_cars), 32'd11);
        light_cfg[3] = RED;
        applyStimulus(4'b0000, 4'b1000);
        checkIdle("lane3 red req");
        checkOutput("lane3 red total", 32'(total_cars), 32'd11);
        applyStimulus(4'b0000, 4'b0000);
        checkIdle("lane3 red req next");
        checkOutput("lane3 red total next", 32'(total_cars), 32'd11);

        // Once green again, a fresh request on lane 3 is served.
        light_cfg[3] = GREEN;
        applyStimulus(4'b0000, 4'b1000);
        checkOutput("lane3 green grant", 32'(cross_grant), 32'h8);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("lane3 back to 0", 32'(car_counter[3]), 32'd0);
        checkOutput("final total", 32'(total_cars), 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
